// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART-side bundle for the TX arbiter.
// master = clients + uart FIFO side, slave = arbiter.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DBIT = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DBIT-1:0] req_data;
  logic [NREQ-1:0]      req_last;
  logic [NREQ-1:0]      req_ready;
  logic                 tx_full;
  logic                 wr_uart;
  logic [DBIT-1:0]      w_data;
  logic [IW-1:0]        grant_id;
  logic                 busy;

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, wr_uart, w_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, wr_uart, w_data, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter in front of the UART TX FIFO.
// Optional ID header byte per grant: define UART_ARB_ID_HDR_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int DBIT    = 8,
  parameter int MAX_MSG = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef UART_ARB_ID_HDR_EN
    HDR  = 2'd1,
`endif
    XFER = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] gid;
  logic [IW-1:0] pick;
  logic [IW-1:0] nxt_ptr;
  logic          found;
  logic          xfer_wr;
  logic          last_hit;
  logic          cap_hit;
  logic          wr;
  logic [DBIT-1:0] data;
  int            idx;

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  always_comb begin
    xfer_wr = (state == XFER)
            & bus.req_valid[gid]
            & ~bus.tx_full;
    wr   = xfer_wr;
    data = '0;
    if (xfer_wr)
      data = bus.req_data[int'(gid)*DBIT +: DBIT];
`ifdef UART_ARB_ID_HDR_EN
    if (state == HDR && !bus.tx_full) begin
      wr   = 1'b1;
      data = DBIT'({4'hA, 4'(gid)});
    end
`endif
  end

  assign last_hit = xfer_wr & bus.req_last[gid];
  assign nxt_ptr  = (gid == IW'(NREQ - 1)) ? '0
                  : gid + 1'b1;

  generate
    if (MAX_MSG > 0) begin : g_cap
      localparam int CW = $clog2(MAX_MSG + 1);
      logic [CW-1:0] byte_cnt;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
          byte_cnt <= '0;
        else if (state == IDLE)
          byte_cnt <= '0;
        else if (xfer_wr)
          byte_cnt <= byte_cnt + 1'b1;
      end

      // This write is byte MAX_MSG of the grant.
      assign cap_hit = xfer_wr
                     & (byte_cnt == CW'(MAX_MSG - 1));
    end else begin : g_nocap
      assign cap_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gid    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            gid <= pick;
`ifdef UART_ARB_ID_HDR_EN
            state <= HDR;
`else
            state <= XFER;
`endif
          end
        end
`ifdef UART_ARB_ID_HDR_EN
        HDR: begin
          if (!bus.tx_full) state <= XFER;
        end
`endif
        XFER: begin
          if (last_hit || cap_hit) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.wr_uart   = wr;
  assign bus.w_data    = data;
  assign bus.req_ready = xfer_wr ? (NREQ'(1) << gid)
                       : '0;
  assign bus.grant_id  = gid;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter
// against a message-level round-robin model.
module tb_uart_tx_arbiter;
  localparam int NREQ    = 4;
  localparam int DBIT    = 8;
  localparam int MAX_MSG = 16;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus();

  uart_tx_arbiter #(
    .NREQ(NREQ), .DBIT(DBIT), .MAX_MSG(MAX_MSG)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [8:0]  q[NREQ][$];
  logic [8:0]  mq[NREQ][$];
  logic [11:0] wlog[$];
  logic [11:0] ex[$];
  logic        full = 1'b0;

  logic       o_wr, o_busy;
  logic [7:0] o_data;
  logic [1:0] o_gid;
  logic [3:0] o_ready;
  logic [3:0] v;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      v[i] = q[i].size() > 0;
      bus.req_valid[i] = v[i];
      bus.req_last[i]  = v[i] ? q[i][0][8] : 1'b0;
      bus.req_data[i*DBIT +: DBIT] =
        v[i] ? q[i][0][7:0] : 8'h00;
    end
    bus.tx_full = full;
  endtask

  task automatic sample();
    o_wr    = bus.wr_uart;
    o_busy  = bus.busy;
    o_data  = bus.w_data;
    o_gid   = bus.grant_id;
    o_ready = bus.req_ready;
  endtask

  task automatic tick();
    logic [3:0] er;
    drive();
    #1;
    sample();
    er = o_wr ? (4'b0001 << o_gid) : 4'b0000;
`ifndef UART_ARB_ID_HDR_EN
    chk("ready_vs_wr", 32'(o_ready), 32'(er));
`endif
    if (!o_wr) chk("wdata_idle", 32'(o_data), 0);
    if (o_wr) begin
      chk("wr_busy", 32'(o_busy), 1);
      wlog.push_back({2'b00, o_gid, o_data});
    end
    @(posedge clk);
    for (int i = 0; i < NREQ; i++)
      if (o_ready[i] && v[i]) void'(q[i].pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    full    = 1'b0;
    for (int i = 0; i < NREQ; i++) q[i].delete();
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  function automatic bit pending();
    for (int i = 0; i < NREQ; i++)
      if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input int bound,
                       input bit rnd_full);
    int n = 0;
    while (pending() && n < bound) begin
      full = rnd_full ? ($urandom_range(0, 3) == 0)
                      : 1'b0;
      tick();
      n++;
    end
    full = 1'b0;
    chk("drain_timeout", 32'(pending()), 0);
  endtask

  // Message-level round robin over the queued bytes.
  task automatic build_model();
    int rr = 0;
    int j, n;
    logic [8:0] e;
    ex.delete();
    for (int i = 0; i < NREQ; i++) mq[i] = q[i];
    forever begin
      j = -1;
      for (int k = 0; k < NREQ; k++)
        if (j < 0 && mq[(rr + k) % NREQ].size() > 0)
          j = (rr + k) % NREQ;
      if (j < 0) break;
`ifdef UART_ARB_ID_HDR_EN
      ex.push_back({2'b00, 2'(j), 4'hA, 4'(j)});
`endif
      n = 0;
      do begin
        e = mq[j].pop_front();
        ex.push_back({2'b00, 2'(j), e[7:0]});
        n++;
      end while (!e[8] && n < MAX_MSG);
      rr = (j + 1) % NREQ;
    end
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_count"}, wlog.size(), ex.size());
    for (int n = 0; n < wlog.size() && n < ex.size(); n++)
      chk({tag, "_byte"}, 32'(wlog[n]), 32'(ex[n]));
  endtask

  logic [7:0] t1d[3];
  logic [1:0] t2id[5];
  logic [7:0] t2d[5];

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_full   = 1'b0;
    @(negedge clk);
    tick();
    chk("rst_busy",  32'(o_busy), 0);
    chk("rst_wr",    32'(o_wr), 0);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_wdata", 32'(o_data), 0);
    chk("rst_gid",   32'(o_gid), 0);
    reset_n = 1'b1;

    // single 3-byte message from req0
    t1d = '{8'h11, 8'h22, 8'h33};
    q[0].push_back(9'h011);
    q[0].push_back(9'h022);
    q[0].push_back(9'h133);
    tick();
    chk("t1_arb_wr",   32'(o_wr), 0);
    chk("t1_arb_busy", 32'(o_busy), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t1_wr",   32'(o_wr), 1);
      chk("t1_data", 32'(o_data), 32'(t1d[k]));
      chk("t1_gid",  32'(o_gid), 0);
    end
    tick();
    chk("t1_end_busy", 32'(o_busy), 0);

    // four requesters, 1-byte messages
    do_reset();
    t2id = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    t2d  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    q[0].push_back(9'h1A0);
    q[0].push_back(9'h1A4);
    q[1].push_back(9'h1A1);
    q[2].push_back(9'h1A2);
    q[3].push_back(9'h1A3);
    for (int m = 0; m < 5; m++) begin
      tick();
      chk("t2_gap_busy", 32'(o_busy), 0);
      chk("t2_gap_wr",   32'(o_wr), 0);
      tick();
      chk("t2_wr",   32'(o_wr), 1);
      chk("t2_gid",  32'(o_gid), 32'(t2id[m]));
      chk("t2_data", 32'(o_data), 32'(t2d[m]));
    end

    // tx_full stall mid-message on req1
    q[1].push_back(9'h0B1);
    q[1].push_back(9'h0B2);
    q[1].push_back(9'h1B3);
    tick();
    tick();
    chk("t3_b1", 32'(o_data), 32'hB1);
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_stall_wr",    32'(o_wr), 0);
      chk("t3_stall_ready", 32'(o_ready), 0);
      chk("t3_stall_busy",  32'(o_busy), 1);
    end
    full = 1'b0;
    tick();
    chk("t3_b2_wr", 32'(o_wr), 1);
    chk("t3_b2",    32'(o_data), 32'hB2);
    tick();
    chk("t3_b3",    32'(o_data), 32'hB3);

    // length cap: req2 20 bytes, req3 waiting
    for (int k = 0; k < 20; k++)
      q[2].push_back({k == 19, 8'(8'h40 + k)});
    q[3].push_back(9'h0C0);
    q[3].push_back(9'h1C1);
    build_model();
    wlog.delete();
    drain(200, 1'b0);
    tick();
    chk("t4_seg1_last",
        32'(ex[MAX_MSG-1]), 32'h24F);
    cmp_log("t4");

    // async reset during req0 byte 2
    q[0].push_back(9'h0D1);
    q[0].push_back(9'h0D2);
    q[0].push_back(9'h0D3);
    q[0].push_back(9'h1D4);
    tick();
    tick();
    chk("t5_d1", 32'(o_data), 32'hD1);
    drive();
    #1;
    sample();
    chk("t5_d2_pre", 32'(o_data), 32'hD2);
    reset_n = 1'b0;
    #1;
    sample();
    chk("t5_rst_wr",    32'(o_wr), 0);
    chk("t5_rst_busy",  32'(o_busy), 0);
    chk("t5_rst_ready", 32'(o_ready), 0);
    chk("t5_rst_data",  32'(o_data), 0);
    chk("t5_rst_gid",   32'(o_gid), 0);
    @(posedge clk);
    @(negedge clk);
    q[3].push_back(9'h1E3);
    reset_n = 1'b1;
    tick();
    chk("t5_arb_busy", 32'(o_busy), 0);
    tick();
    chk("t5_regrant_gid", 32'(o_gid), 0);
    chk("t5_regrant_d2",  32'(o_data), 32'hD2);
    tick();
    tick();
    chk("t5_d4", 32'(o_data), 32'hD4);
    tick();
    tick();
    chk("t5_req3_gid",  32'(o_gid), 3);
    chk("t5_req3_data", 32'(o_data), 32'hE3);

    // single-byte message, header only with macro
    do_reset();
    q[3].push_back(9'h155);
    tick();
`ifdef UART_ARB_ID_HDR_EN
    tick();
    chk("t6_hdr", 32'(o_data), 32'hA3);
`endif
    tick();
    chk("t6_wr",   32'(o_wr), 1);
    chk("t6_data", 32'(o_data), 32'h55);

    // randomized traffic with random back-pressure
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      int nm = $urandom_range(0, 3);
      for (int m = 0; m < nm; m++) begin
        int len = $urandom_range(1, 20);
        for (int b = 0; b < len; b++)
          q[i].push_back({b == len - 1,
                          8'($urandom)});
      end
    end
    q[1].push_back(9'h177);
    build_model();
    wlog.delete();
    drain(4000, 1'b1);
    tick();
    cmp_log("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
